fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps at most one imem request in flight, parks a response
// that arrives while decode is stalled, and drives the IF/ID pipeline register.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [1:0]  fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_pc;
    logic [31:0] buf_instr;
    logic [31:0] buf_pc;
    logic [31:0] target;
    logic        deliver;
    logic [31:0] deliver_instr;
    logic [31:0] deliver_pc;

    assign target    = redirect_pc & 32'hFFFF_FFFC;
    // Handshake: memory accepts imem_req in the cycle it is high (no ready); it answers
    // each request with exactly one imem_rvalid pulse, no earlier than the next cycle.
    assign imem_req  = rst_n && (state == IDLE) && !redirect && !(stall && id_valid);
    assign imem_addr = pc;
    assign fsm_state = state;

    // Candidate instruction for the ID register: a live response or the parked one.
    always_comb begin
        deliver       = 1'b0;
        deliver_instr = imem_rdata;
        deliver_pc    = req_pc;
        if (state == WAIT && imem_rvalid) begin
            deliver = 1'b1;
        end else if (state == HOLD) begin
            deliver       = 1'b1;
            deliver_instr = buf_instr;
            deliver_pc    = buf_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            req_pc    <= 32'h0;
            buf_instr <= 32'h0;
            buf_pc    <= 32'h0;
            id_valid  <= 1'b0;
            id_instr  <= NOP_INSTR;
            id_pc     <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect) begin
                        pc <= target;
                    end else if (imem_req) begin
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                        state  <= WAIT;
                    end
                end
                WAIT: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= imem_rvalid ? IDLE : DROP;
                    end else if (imem_rvalid) begin
                        if (stall) begin
                            buf_instr <= imem_rdata;
                            buf_pc    <= req_pc;
                            state     <= HOLD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc    <= target;
                        state <= IDLE;
                    end else if (!stall) begin
                        state <= IDLE;
                    end
                end
                DROP: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    if (imem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Redirect flushes ID even while decode is stalled.
            if (redirect) begin
                id_valid <= 1'b0;
                id_instr <= NOP_INSTR;
            end else if (!stall) begin
                if (deliver) begin
                    id_valid <= 1'b1;
                    id_instr <= deliver_instr;
                    id_pc    <= deliver_pc;
                end else begin
                    id_valid <= 1'b0;
                    id_instr <= NOP_INSTR;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic checked
// against a flag-based transaction model of the fetch rules.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_HOLD  = 2'd2;
    localparam logic [1:0]  ST_DROP  = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [1:0]  fsm_state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .id_valid(id_valid),
        .id_instr(id_instr), .id_pc(id_pc), .fsm_state(fsm_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0;
        repeat (3) tick();
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL reset_req: imem_req=%0b want 0", imem_req);
        end
        checks++;
        if ({id_valid, id_instr, id_pc, fsm_state} !== {1'b0, NOP, 32'h0, ST_IDLE}) begin
            errors++;
            $display("FAIL reset_id: valid=%0b instr=%h pc=%h st=%0d want 0/%h/0/0",
                     id_valid, id_instr, id_pc, fsm_state, NOP);
        end
    endtask

    task automatic test_basic();
        rst_n = 1'b1;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
            errors++; $display("FAIL first_req: req=%0b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
        end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0641_0093;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL wait_no_req: imem_req=%0b want 0", imem_req);
        end
        tick();
        checks++;
        if ({id_valid, id_instr, id_pc} !== {1'b1, 32'h0641_0093, 32'h0}) begin
            errors++; $display("FAIL basic_id0: valid=%0b instr=%h pc=%h want 1/06410093/0", id_valid, id_instr, id_pc);
        end
        imem_rvalid = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin
            errors++; $display("FAIL second_req: req=%0b addr=%h want 1/4", imem_req, imem_addr);
        end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0642_2183;
        tick();
        checks++;
        if ({id_valid, id_instr, id_pc} !== {1'b1, 32'h0642_2183, 32'h4}) begin
            errors++; $display("FAIL basic_id1: valid=%0b instr=%h pc=%h want 1/06422183/4", id_valid, id_instr, id_pc);
        end
        imem_rvalid = 1'b0;
    endtask

    task automatic test_stall();
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
            errors++; $display("FAIL stall_req8: req=%0b addr=%h want 1/8", imem_req, imem_addr);
        end
        tick();
        stall = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h0053_2223;
        tick();
        checks++;
        if ({fsm_state, id_valid, id_instr, id_pc} !== {ST_HOLD, 1'b0, NOP, 32'h4}) begin
            errors++;
            $display("FAIL stall_hold: st=%0d valid=%0b instr=%h pc=%h want 2/0/%h/4",
                     fsm_state, id_valid, id_instr, id_pc, NOP);
        end
        imem_rvalid = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL hold_no_req: imem_req=%0b want 0", imem_req);
        end
        tick();
        checks++;
        if ({id_valid, id_instr, id_pc} !== {1'b0, NOP, 32'h4}) begin
            errors++; $display("FAIL stall_keep: valid=%0b instr=%h pc=%h want 0/%h/4", id_valid, id_instr, id_pc, NOP);
        end
        stall = 1'b0;
        tick();
        checks++;
        if ({id_valid, id_instr, id_pc, fsm_state} !== {1'b1, 32'h0053_2223, 32'h8, ST_IDLE}) begin
            errors++;
            $display("FAIL stall_release: valid=%0b instr=%h pc=%h st=%0d want 1/00532223/8/0",
                     id_valid, id_instr, id_pc, fsm_state);
        end
    endtask

    task automatic test_redirect_wait();
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        tick();
        checks++;
        if ({fsm_state, id_valid, id_instr} !== {ST_DROP, 1'b0, NOP}) begin
            errors++; $display("FAIL redir_drop: st=%0d valid=%0b instr=%h want 3/0/%h", fsm_state, id_valid, id_instr, NOP);
        end
        redirect = 1'b0;
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        checks++;
        if ({id_valid, id_instr} !== {1'b0, NOP}) begin
            errors++; $display("FAIL redir_discard: valid=%0b instr=%h want 0/%h", id_valid, id_instr, NOP);
        end
        imem_rvalid = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin
            errors++; $display("FAIL redir_target: req=%0b addr=%h want 1/100", imem_req, imem_addr);
        end
        tick();
    endtask

    task automatic test_redirect_rvalid();
        imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
        redirect = 1'b1; redirect_pc = 32'h0000_0200;
        tick();
        checks++;
        if ({id_valid, id_instr, fsm_state} !== {1'b0, NOP, ST_IDLE}) begin
            errors++; $display("FAIL same_cycle_id: valid=%0b instr=%h st=%0d want 0/%h/0", id_valid, id_instr, fsm_state, NOP);
        end
        redirect = 1'b0; imem_rvalid = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h200}) begin
            errors++; $display("FAIL same_cycle_req: req=%0b addr=%h want 1/200", imem_req, imem_addr);
        end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0093;
        tick();
        checks++;
        if ({id_valid, id_instr, id_pc} !== {1'b1, 32'h00A0_0093, 32'h200}) begin
            errors++; $display("FAIL target_fetch: valid=%0b instr=%h pc=%h want 1/00a00093/200", id_valid, id_instr, id_pc);
        end
        imem_rvalid = 1'b0;
    endtask

    task automatic test_redirect_stall();
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0300;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL rs_no_req: imem_req=%0b want 0", imem_req);
        end
        tick();
        checks++;
        if ({id_valid, id_instr} !== {1'b0, NOP}) begin
            errors++; $display("FAIL rs_flush: valid=%0b instr=%h want 0/%h", id_valid, id_instr, NOP);
        end
        stall = 1'b0; redirect = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h300}) begin
            errors++; $display("FAIL rs_target: req=%0b addr=%h want 1/300", imem_req, imem_addr);
        end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h1234_5678;
        tick();
        imem_rvalid = 1'b0;
    endtask

    task automatic test_wrap_and_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++; $display("FAIL top_addr: req=%0b addr=%h want 1/fffffffc", imem_req, imem_addr);
        end
        tick();
        imem_rvalid = 1'b1; imem_rdata = 32'h0010_0073;
        tick();
        checks++;
        if ({id_valid, id_instr, id_pc} !== {1'b1, 32'h0010_0073, 32'hFFFF_FFFC}) begin
            errors++; $display("FAIL top_id: valid=%0b instr=%h pc=%h want 1/00100073/fffffffc", id_valid, id_instr, id_pc);
        end
        imem_rvalid = 1'b0;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL wrap_addr: req=%0b addr=%h want 1/0", imem_req, imem_addr);
        end
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++; $display("FAIL rst_wait_req: imem_req=%0b want 0", imem_req);
        end
        tick();
        checks++;
        if ({id_valid, id_instr, id_pc} !== {1'b0, NOP, 32'h0}) begin
            errors++; $display("FAIL rst_wait_id: valid=%0b instr=%h pc=%h want 0/%h/0", id_valid, id_instr, id_pc, NOP);
        end
        rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00;
        #1;
        checks++;
        if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin
            errors++; $display("FAIL rst_refetch: req=%0b addr=%h want 1/%h", imem_req, imem_addr, RESET_PC);
        end
        tick();
        checks++;
        if ({id_valid, id_instr} !== {1'b0, NOP}) begin
            errors++; $display("FAIL late_rvalid: valid=%0b instr=%h want 0/%h", id_valid, id_instr, NOP);
        end
        imem_rdata = 32'h0641_0093;
        tick();
        checks++;
        if ({id_valid, id_instr, id_pc} !== {1'b1, 32'h0641_0093, RESET_PC}) begin
            errors++; $display("FAIL rst_first_id: valid=%0b instr=%h pc=%h want 1/06410093/0", id_valid, id_instr, id_pc);
        end
        imem_rvalid = 1'b0;
    endtask

    task automatic test_random();
        logic        m_busy, m_drop, m_buf_full, m_id_valid, exp_req, deliver, req_seen, mem_busy;
        logic [31:0] m_pc, m_req_pc, m_buf_instr, m_buf_pc, m_id_instr, m_id_pc;
        logic [31:0] d_instr, d_pc, addr_seen, mem_addr;
        int          mem_cnt;
        m_busy = 1'b0; m_drop = 1'b0; m_buf_full = 1'b0; m_id_valid = 1'b0;
        m_pc = RESET_PC; m_req_pc = 32'h0; m_buf_instr = 32'h0; m_buf_pc = 32'h0;
        m_id_instr = NOP; m_id_pc = 32'h0; mem_busy = 1'b0; mem_cnt = 0; mem_addr = 32'h0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst_n       = !(cyc < 2 || $urandom_range(0, 299) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = $urandom;
            if (mem_busy && mem_cnt == 0) begin
                imem_rvalid = 1'b1; imem_rdata = instr_of(mem_addr);
            end else if (!mem_busy && $urandom_range(0, 7) == 0) begin
                imem_rvalid = 1'b1; imem_rdata = $urandom;
            end else begin
                imem_rvalid = 1'b0; imem_rdata = $urandom;
            end
            exp_req = rst_n && !m_busy && !m_buf_full && !redirect && !(stall && m_id_valid);
            #1;
            checks++;
            if (imem_req !== exp_req || (exp_req && imem_addr !== m_pc)) begin
                errors++;
                $display("FAIL rnd_req cyc=%0d: req=%0b addr=%h want %0b/%h", cyc, imem_req, imem_addr, exp_req, m_pc);
            end
            req_seen = imem_req; addr_seen = imem_addr;
            @(posedge clk);
            if (!rst_n) begin
                m_busy = 1'b0; m_drop = 1'b0; m_buf_full = 1'b0; m_pc = RESET_PC;
                m_id_valid = 1'b0; m_id_instr = NOP; m_id_pc = 32'h0; mem_busy = 1'b0;
            end else begin
                deliver = 1'b0; d_instr = NOP; d_pc = 32'h0;
                if (m_busy) begin
                    if (imem_rvalid) begin
                        if (!m_drop && !redirect) begin
                            if (stall) begin
                                m_buf_full = 1'b1; m_buf_instr = imem_rdata; m_buf_pc = m_req_pc;
                            end else begin
                                deliver = 1'b1; d_instr = imem_rdata; d_pc = m_req_pc;
                            end
                        end
                        m_busy = 1'b0; m_drop = 1'b0;
                    end else if (redirect) begin
                        m_drop = 1'b1;
                    end
                end else if (m_buf_full) begin
                    if (redirect) begin
                        m_buf_full = 1'b0;
                    end else if (!stall) begin
                        deliver = 1'b1; d_instr = m_buf_instr; d_pc = m_buf_pc; m_buf_full = 1'b0;
                    end
                end
                if (redirect) begin
                    m_pc = redirect_pc & 32'hFFFF_FFFC;
                end else if (exp_req) begin
                    m_busy = 1'b1; m_drop = 1'b0; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
                end
                if (redirect) begin
                    m_id_valid = 1'b0; m_id_instr = NOP;
                end else if (!stall) begin
                    m_id_valid = deliver;
                    m_id_instr = deliver ? d_instr : NOP;
                    if (deliver) m_id_pc = d_pc;
                end
                if (mem_busy) begin
                    if (mem_cnt == 0) mem_busy = 1'b0;
                    else mem_cnt--;
                end
                if (req_seen) begin
                    mem_busy = 1'b1; mem_cnt = $urandom_range(0, 2); mem_addr = addr_seen;
                end
            end
            #1;
            checks++;
            if ({id_valid, id_instr, id_pc} !== {m_id_valid, m_id_instr, m_id_pc}) begin
                errors++;
                $display("FAIL rnd_id cyc=%0d: valid=%0b instr=%h pc=%h want %0b/%h/%h",
                         cyc, id_valid, id_instr, id_pc, m_id_valid, m_id_instr, m_id_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_redirect_stall();
        test_wrap_and_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
